// File: rtl/line_stream_ctrl.sv
// Streams a row_length x col_length frame from memory into a line buffer,
// absorbing downstream stalls with a one-entry hold register and flagging 3x3 window origins.
module line_stream_ctrl #(
  parameter int WID_LINE  = 16,
  parameter int ADDR_FIFO = 9,
  parameter int ADDR_MEM  = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_FIFO-1:0] row_length,
  input  logic [ADDR_FIFO-1:0] col_length,
  input  logic [ADDR_MEM-1:0]  base_addr,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [ADDR_MEM-1:0]  mem_addr,
  input  logic [WID_LINE-1:0]  mem_rd_data,
  output logic [WID_LINE-1:0]  lb_inp,
  output logic                 lb_shifting,
  output logic                 lb_reset,
  output logic                 win_valid,
  output logic [ADDR_FIFO-1:0] win_row,
  output logic [ADDR_FIFO-1:0] win_col,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  // One extra bit so a frame of exactly 2^ADDR_MEM pixels still counts correctly.
  localparam int CNT_W  = ADDR_MEM + 1;
  localparam int PROD_W = 2 * ADDR_FIFO;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH} state_t;

  state_t               state_reg, state_next;
  logic                 cfg_err_reg, done_reg;
  logic [ADDR_FIFO-1:0] row_len_reg;
  logic [CNT_W-1:0]     total_reg, rd_left_reg, px_cnt_reg;
  logic [ADDR_MEM-1:0]  addr_reg;
  logic                 rd_pend_reg;
  logic                 hold_valid_reg;
  logic [WID_LINE-1:0]  hold_data_reg;
  logic [ADDR_FIFO-1:0] col_reg, row_reg;
  logic                 win_valid_reg, last_px_reg;
  logic [ADDR_FIFO-1:0] win_row_reg, win_col_reg;

  logic                 cfg_bad;
  logic [PROD_W-1:0]    frame_px;
  logic                 rd_fire;
  logic                 shift;

  always_comb begin
    cfg_bad  = (row_length < ADDR_FIFO'(3)) || (col_length < ADDR_FIFO'(3));
    frame_px = PROD_W'(row_length) * PROD_W'(col_length);
    // A pixel leaves either from the hold register or straight off the memory return.
    shift    = !stall && (hold_valid_reg || rd_pend_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start && !cfg_bad) state_next = S_CLEAR;
      S_CLEAR:  state_next = S_STREAM;
      S_STREAM: if (rd_fire && rd_left_reg == CNT_W'(1)) state_next = S_FLUSH;
      S_FLUSH:  if (last_px_reg) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != S_IDLE);
    lb_reset    = (state_reg == S_CLEAR);
    rd_fire     = (state_reg == S_STREAM) && !stall && !hold_valid_reg && (rd_left_reg != '0);
    mem_rd_en   = rd_fire;
    mem_addr    = rd_fire ? addr_reg : '0;
    lb_shifting = shift;
    lb_inp      = '0;
    if (shift) lb_inp = hold_valid_reg ? hold_data_reg : mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_reg    <= 1'b0;
      done_reg       <= 1'b0;
      row_len_reg    <= '0;
      total_reg      <= '0;
      rd_left_reg    <= '0;
      px_cnt_reg     <= '0;
      addr_reg       <= '0;
      rd_pend_reg    <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      win_valid_reg  <= 1'b0;
      last_px_reg    <= 1'b0;
      win_row_reg    <= '0;
      win_col_reg    <= '0;
    end else begin
      rd_pend_reg   <= rd_fire;
      done_reg      <= 1'b0;
      win_valid_reg <= 1'b0;
      last_px_reg   <= 1'b0;

      if (state_reg == S_IDLE && start) begin
        if (cfg_bad) begin
          cfg_err_reg <= 1'b1;
          done_reg    <= 1'b1;
        end else begin
          cfg_err_reg <= 1'b0;
          row_len_reg <= row_length;
          total_reg   <= CNT_W'(frame_px);
          rd_left_reg <= CNT_W'(frame_px);
          addr_reg    <= base_addr;
          px_cnt_reg  <= '0;
          col_reg     <= '0;
          row_reg     <= '0;
        end
      end

      if (rd_fire) begin
        addr_reg    <= addr_reg + ADDR_MEM'(1);
        rd_left_reg <= rd_left_reg - CNT_W'(1);
      end

      // At most one read is ever in flight, so the hold register never overflows.
      if (rd_pend_reg && stall) begin
        hold_valid_reg <= 1'b1;
        hold_data_reg  <= mem_rd_data;
      end else if (hold_valid_reg && !stall) begin
        hold_valid_reg <= 1'b0;
      end

      if (shift) begin
        px_cnt_reg  <= px_cnt_reg + CNT_W'(1);
        last_px_reg <= (px_cnt_reg == total_reg - CNT_W'(1));
        if (col_reg == row_len_reg - ADDR_FIFO'(1)) begin
          col_reg <= '0;
          row_reg <= row_reg + ADDR_FIFO'(1);
        end else begin
          col_reg <= col_reg + ADDR_FIFO'(1);
        end
        if (row_reg >= ADDR_FIFO'(2) && col_reg >= ADDR_FIFO'(2)) begin
          win_valid_reg <= 1'b1;
          win_row_reg   <= row_reg - ADDR_FIFO'(2);
          win_col_reg   <= col_reg - ADDR_FIFO'(2);
        end
      end

      // The final window strobe coincides with last_px_reg; done follows one cycle later.
      if (state_reg == S_FLUSH && last_px_reg) done_reg <= 1'b1;
    end
  end

  assign win_valid = win_valid_reg;
  assign win_row   = win_row_reg;
  assign win_col   = win_col_reg;
  assign done      = done_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_line_stream_ctrl.sv
// Directed bench for line_stream_ctrl: a frame-level model predicts reads, pixels,
// windows and done from the frame geometry; directed scenarios add literal checks.
module tb_line_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  row_length;
  logic [8:0]  col_length;
  logic [17:0] base_addr;
  logic        stall;
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] lb_inp;
  logic        lb_shifting;
  logic        lb_reset;
  logic        win_valid;
  logic [8:0]  win_row;
  logic [8:0]  win_col;
  logic        busy;
  logic        done;
  logic        cfg_err;

  line_stream_ctrl #(.WID_LINE(16), .ADDR_FIFO(9), .ADDR_MEM(18)) dut (
    .clk(clk), .rst(rst), .start(start), .row_length(row_length), .col_length(col_length),
    .base_addr(base_addr), .stall(stall), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .lb_inp(lb_inp), .lb_shifting(lb_shifting), .lb_reset(lb_reset),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] pix(input logic [17:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'h0000_9E37;
    return t[15:0] ^ t[31:16] ^ 16'h5A5A;
  endfunction

  // Memory: data appears one cycle after the request; anything unrequested is junk.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? pix(mem_addr) : 16'hDEAD;

  // Frame model state
  logic [17:0] m_base;
  int  m_rl, n_total, nwin;
  bit  model_on = 1'b0;
  int  rd_cnt, sh_cnt, win_cnt, lbr_total = 0;
  bit  exp_win_q, exp_done_q;
  int  exp_row_q, exp_col_q;
  int  first_row, first_col, last_row, last_col;

  always @(negedge clk) begin : cmp
    int r, c;
    if (rst && lb_reset) lbr_total++;
    if (!rst || !model_on) begin
      exp_win_q  = 1'b0;
      exp_done_q = 1'b0;
    end else begin
      if (lb_reset) begin
        rd_cnt = 0; sh_cnt = 0; win_cnt = 0;
        exp_win_q = 1'b0; exp_done_q = 1'b0;
      end
      chk("done", done, exp_done_q);
      exp_done_q = 1'b0;
      chk("win_valid", win_valid, exp_win_q);
      if (win_valid && exp_win_q) begin
        chk("win_row", win_row, exp_row_q);
        chk("win_col", win_col, exp_col_q);
        if (win_cnt == 0) begin first_row = win_row; first_col = win_col; end
        last_row = win_row; last_col = win_col;
        win_cnt++;
        exp_done_q = (win_cnt == nwin);
      end
      exp_win_q = 1'b0;
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr, m_base + 18'(rd_cnt));
        chk("rd_in_range", rd_cnt < n_total, 1);
        chk("rd_stall", stall, 0);
        rd_cnt++;
      end
      if (lb_shifting) begin
        chk("shift_stall", stall, 0);
        chk("lb_inp", lb_inp, pix(m_base + 18'(sh_cnt)));
        r = sh_cnt / m_rl;
        c = sh_cnt % m_rl;
        if (r >= 2 && c >= 2) begin
          exp_win_q = 1'b1; exp_row_q = r - 2; exp_col_q = c - 2;
        end
        sh_cnt++;
        chk("shift_in_range", sh_cnt <= n_total, 1);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_lb_inp"}, lb_inp, 0);
    chk({tag, "_shift"}, lb_shifting, 0);
    chk({tag, "_lb_reset"}, lb_reset, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic run_frame(input logic [17:0] b, input int rl, input int cl, input int stall_at,
                           input int stall_len, input int mid_at, output int lat);
    int rd_seen, stall_left, lbr0;
    bit got_done, release_chk;
    m_base = b; m_rl = rl; n_total = rl * cl; nwin = (rl - 2) * (cl - 2); model_on = 1'b1;
    base_addr = b; row_length = 9'(rl); col_length = 9'(cl);
    lbr0 = lbr_total; lat = 0; rd_seen = 0; stall_left = 0; got_done = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    while (!got_done && lat < 3000) begin
      @(posedge clk); #1;
      start = (lat == mid_at);
      row_length = (lat == mid_at) ? 9'd3 : 9'(rl);
      release_chk = 1'b0;
      if (stall_left > 0) begin stall = 1'b1; stall_left--; end
      else if (stall) begin stall = 1'b0; release_chk = 1'b1; end
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("clear_lb_reset", lb_reset, 1);
        chk("clear_busy", busy, 1);
        chk("clear_cfg_err", cfg_err, 0);
      end
      if (lat == 2) begin
        chk("first_rd_en", mem_rd_en, 1);
        chk("first_rd_addr", mem_addr, b);
      end
      if (release_chk) begin
        chk("hold_emit", lb_shifting, 1);
        chk("hold_no_read", mem_rd_en, 0);
      end
      if (mem_rd_en) begin
        if (rd_seen == stall_at && stall_len > 0) stall_left = stall_len;
        rd_seen++;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0; stall = 1'b0;
    chk("done_seen", got_done, 1);
    @(negedge clk); #1;
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
    chk("total_reads", rd_cnt, n_total);
    chk("total_shifts", sh_cnt, n_total);
    chk("total_windows", win_cnt, nwin);
    chk("lb_reset_cycles", lbr_total - lbr0, 1);
    $display("frame base=0x%0h %0dx%0d: latency=%0d reads=%0d shifts=%0d windows=%0d",
             b, rl, cl, lat, rd_cnt, sh_cnt, win_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, shifts, cyc;
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    row_length = 9'd4; col_length = 9'd4; base_addr = '0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // 4x4, no stall: reads 0x100..0x10F, windows (0,0)..(1,1), done at N+4
    run_frame(18'h100, 4, 4, -1, 0, -1, lat);
    chk("lat_4x4", lat, 20);
    chk("win_cnt_4x4", win_cnt, 4);
    chk("first_win_4x4", {first_row[15:0], first_col[15:0]}, 32'h0000_0000);
    chk("last_win_4x4", {last_row[15:0], last_col[15:0]}, 32'h0001_0001);

    // 3x3: a single window at (0,0)
    run_frame(18'h2000, 3, 3, -1, 0, -1, lat);
    chk("lat_3x3", lat, 13);
    chk("win_cnt_3x3", win_cnt, 1);
    chk("win_3x3", {last_row[15:0], last_col[15:0]}, 32'h0000_0000);

    // 5x4 with a 5-cycle stall landing on an in-flight read
    run_frame(18'h300, 5, 4, 2, 5, -1, lat);
    chk("shifts_5x4", sh_cnt, 20);
    chk("win_cnt_5x4", win_cnt, 6);
    chk("last_win_5x4", {last_row[15:0], last_col[15:0]}, 32'h0001_0002);

    // Bad geometry: cfg_err, done next cycle, never a read
    model_on = 1'b0;
    row_length = 9'd2; col_length = 9'd4;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_done", done, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_no_read", mem_rd_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cfg_err_hold", cfg_err, 1);
      chk("cfg_err_done_once", done, 0);
      chk("cfg_err_no_read2", mem_rd_en, 0);
    end
    $display("cfg error case: cfg_err=%0b busy=%0b", cfg_err, busy);

    // Next valid start clears cfg_err (checked in the CLEAR cycle)
    run_frame(18'h0, 3, 3, -1, 0, -1, lat);
    chk("cfg_err_cleared", cfg_err, 0);

    // start pulsed mid-STREAM with a different row_length: ignored
    run_frame(18'h100, 4, 4, -1, 0, 6, lat);
    chk("lat_mid_start", lat, 20);

    // Reset while pixel 7 of an 8x8 frame is shifting
    m_base = 18'h4000; m_rl = 8; n_total = 64; nwin = 36; model_on = 1'b1;
    base_addr = 18'h4000; row_length = 9'd8; col_length = 9'd8;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    shifts = 0; cyc = 0;
    while (shifts < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (lb_shifting) shifts++;
    end
    chk("reached_pixel7", shifts, 8);
    #2 model_on = 1'b0; rst = 1'b0;
    #1 chk_all_zero("async_reset");
    $display("reset asserted mid-frame after %0d shifts", shifts);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_shift", lb_shifting, 0);
      chk("idle_no_read", mem_rd_en, 0);
      chk("idle_busy", busy, 0);
    end
    run_frame(18'h4000, 8, 8, -1, 0, -1, lat);
    chk("lat_8x8", lat, 68);
    chk("win_cnt_8x8", win_cnt, 36);
    chk("last_win_8x8", {last_row[15:0], last_col[15:0]}, 32'h0005_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
